washer_timer: RTL and testbench
===============================

# washer_timer

Programmable phase timer that is the responder end of the washing-machine controller's timer interface. It accepts run requests (`TIMER_EN` for the wash phase, `SPIN_EN` for the spin phase) plus a duration select `TIMER_SEL`, counts prescaled ticks, and returns `TIMER_DONE` when the selected phase time has elapsed. It sits beside the controller FSM and is driven only by controller outputs and the system clock.

## Interface
- `PRESCALE`, default 1000: clock cycles per tick; must be ≥1.
- `T_DEFAULT`, default 60: ticks for `TIMER_SEL`=00; must be ≥1.
- `T_WASH_M`, default 300: ticks for `TIMER_SEL`=01 (medium-load wash); must be ≥1.
- `T_WASH_H`, default 600: ticks for `TIMER_SEL`=10 (high-load wash); must be ≥1.
- `T_SPIN`, default 180: ticks for `TIMER_SEL`=11 (spin); must be ≥1.
- `CNT_W`, default 16: width of the tick counter and `REMAINING`; all `T_*` must be < 2^CNT_W.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `TIMER_EN` in 1: wash-phase run request.
- `SPIN_EN` in 1: spin-phase run request.
- `TIMER_SEL` in 2: duration select, sampled only at start.
- `TIMER_DONE` out 1: registered, level, high while expired and the request is held.
- `BUSY` out 1: registered, high in RUN.
- `REMAINING` out CNT_W: registered ticks left.

## Operation
- Request: `REQ = TIMER_EN | SPIN_EN`.
- States: IDLE, RUN, EXPIRED.
- Reset (`RST`=0, asynchronous): state IDLE; `TIMER_DONE`=0, `BUSY`=0, `REMAINING`=0, prescaler=0, latched select=00.
- IDLE -> RUN when `REQ`=1 at a rising edge. On that edge:
  - latch `TIMER_SEL`;
  - `REMAINING` = T(sel);
  - prescaler = 0;
  - `BUSY`=1.
- RUN behaviour:
  - The prescaler increments on each edge.
  - When the prescaler equals `PRESCALE`-1, it wraps to 0 and `REMAINING` decrements.
  - When `REMAINING` decrements from 1 to 0, the same edge moves to EXPIRED, sets `TIMER_DONE`=1 and `BUSY`=0.
- RUN -> IDLE (abort) when `REQ`=0 at an edge. All outputs and counters clear; `TIMER_DONE` never asserts.
- EXPIRED:
  - `TIMER_DONE` holds 1 while `REQ`=1. `REMAINING`=0.
  - When `REQ`=0 at an edge, go to IDLE and `TIMER_DONE`=0.
- Restart needs `REQ` low for ≥1 sampled edge. There is no retrigger from EXPIRED, even if `TIMER_SEL` or the active request source changes.
- `TIMER_SEL` changes during RUN or EXPIRED are ignored.
- `TIMER_EN` and `SPIN_EN` both high is treated as a single request; the select decides the duration.
- Undefined state encodings recover to IDLE with all outputs 0.

## Timing
- Start edge E0 is the first edge sampling `REQ`=1 in IDLE.
- `TIMER_DONE` rises after edge E0 + T(sel)·`PRESCALE`. `BUSY` is high for exactly T(sel)·`PRESCALE` cycles.
- `REMAINING` holds T(sel) for `PRESCALE` cycles after E0, then steps down by 1 every `PRESCALE` cycles.
- Boundary T=1, `PRESCALE`=1: `TIMER_DONE` is high after E0+1.
- `TIMER_DONE` falls at the first edge sampling `REQ`=0. This is one cycle after the controller leaves its timed state.
- Reset release with `REQ`=1: the first edge after release is E0, and a full duration runs.

## Test plan
Parameters: `PRESCALE`=4, `T_DEFAULT`=1, `T_WASH_M`=3, `T_WASH_H`=5, `T_SPIN`=2.
1. `TIMER_EN`=1, `TIMER_SEL`=01 from E0 -> `REMAINING` goes 3 (×4 cycles), 2, 1 (×4 each); `TIMER_DONE`=1 after E0+12; `BUSY` high for 12 cycles. Drop `TIMER_EN` -> `TIMER_DONE`=0 at the next edge.
2. `TIMER_EN`=1, `TIMER_SEL`=10; drop `TIMER_EN` at E0+7 -> IDLE at that edge, `REMAINING`=0, `BUSY`=0, `TIMER_DONE` never 1. Re-raise -> a full 20-cycle run.
3. `SPIN_EN`=1, `TIMER_EN`=0, `TIMER_SEL`=11 -> `TIMER_DONE` after E0+8; hold `SPIN_EN` 5 more cycles -> `TIMER_DONE` stays 1, no restart.
4. `TIMER_SEL`=01 at E0, switched to 10 at E0+3 -> `TIMER_DONE` still at E0+12.
5. Async `RST` low between edges at E0+6 -> all outputs 0 immediately. Release with `TIMER_EN`=1 -> fresh 12-cycle run from the first edge after release.
6. Override `PRESCALE`=1, `TIMER_SEL`=00 -> `TIMER_DONE` at E0+1. Back-to-back requests with `REQ` low for 1 edge in between -> the second run completes normally.

Source files
------------

// File: rtl/washer_timer_if.sv
// Controller-to-timer link: run requests and duration select in one direction,
// expiry/busy/remaining-tick status in the other.
interface washer_timer_if #(
  parameter int CNT_W = 16
);
  logic             TIMER_EN;
  logic             SPIN_EN;
  logic [1:0]       TIMER_SEL;
  logic             TIMER_DONE;
  logic             BUSY;
  logic [CNT_W-1:0] REMAINING;

  modport master (
    output TIMER_EN, SPIN_EN, TIMER_SEL,
    input  TIMER_DONE, BUSY, REMAINING
  );

  modport slave (
    input  TIMER_EN, SPIN_EN, TIMER_SEL,
    output TIMER_DONE, BUSY, REMAINING
  );
endinterface

// File: rtl/washer_timer.sv
// Phase timer: counts T(sel) prescaled ticks from the start edge, then holds
// TIMER_DONE while the request stays high; all outputs registered.
module washer_timer #(
  parameter int PRESCALE  = 1000,
  parameter int T_DEFAULT = 60,
  parameter int T_WASH_M  = 300,
  parameter int T_WASH_H  = 600,
  parameter int T_SPIN    = 180,
  parameter int CNT_W     = 16
) (
  input logic           CLK,
  input logic           RST,
  washer_timer_if.slave tif
);
  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             req;

  assign req = tif.TIMER_EN | tif.SPIN_EN;

  function automatic logic [CNT_W-1:0] dur(input logic [1:0] sel);
    case (sel)
      2'b00:   dur = CNT_W'(T_DEFAULT);
      2'b01:   dur = CNT_W'(T_WASH_M);
      2'b10:   dur = CNT_W'(T_WASH_H);
      default: dur = CNT_W'(T_SPIN);
    endcase
  endfunction

  // The select only matters at the start edge: it is folded into the loaded
  // tick count, so later TIMER_SEL changes cannot affect the running phase.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    rem_d   = '0;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RUN;
          rem_d   = dur(tif.TIMER_SEL);
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (!req) begin
          state_d = IDLE;
        end else if (presc_q == PRESC_LAST) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          rem_d   = rem_q;
          busy_d  = 1'b1;
        end
      end
      EXPIRED: begin
        // No retrigger here: REQ must drop for an edge before a new run.
        if (req) done_d = 1'b1;
        else     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      presc_q <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign tif.TIMER_DONE = done_q;
  assign tif.BUSY       = busy_q;
  assign tif.REMAINING  = rem_q;
endmodule

// File: tb/tb_washer_timer.sv
// Bench for washer_timer: a PRESCALE=4 instance and a PRESCALE=1 instance share stimulus.
module tb_washer_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  washer_timer_if #(.CNT_W(16)) ifa ();
  washer_timer_if #(.CNT_W(16)) ifb ();

  washer_timer #(
    .PRESCALE(4), .T_DEFAULT(1), .T_WASH_M(3), .T_WASH_H(5), .T_SPIN(2), .CNT_W(16)
  ) dut_a (.CLK(clk), .RST(rst_n), .tif(ifa));

  washer_timer #(
    .PRESCALE(1), .T_DEFAULT(1), .T_WASH_M(3), .T_WASH_H(5), .T_SPIN(2), .CNT_W(16)
  ) dut_b (.CLK(clk), .RST(rst_n), .tif(ifb));

  typedef struct {
    logic        en;
    logic        spin;
    logic [1:0]  sel;
    logic        done;
    logic        busy;
    logic [15:0] rem;
    bit          b;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic add_row(input logic en, input logic spin, input logic [1:0] sel,
                         input logic done, input logic busy, input logic [15:0] rem,
                         input bit b, input string tag);
    vec_t v;
    v.en = en; v.spin = spin; v.sel = sel;
    v.done = done; v.busy = busy; v.rem = rem; v.b = b; v.tag = tag;
    vecs.push_back(v);
  endtask

  // n rows of held request starting at E0 (row 0); expectations from the timing formulas.
  task automatic add_run(input logic en, input logic spin, input logic [1:0] sel0,
                         input logic [1:0] sel1, input int sw, input int t, input int p,
                         input int n, input bit b, input string tag);
    for (int j = 0; j < n; j++) begin
      if (j < t * p)
        add_row(en, spin, (j < sw) ? sel0 : sel1, 1'b0, 1'b1, 16'(t - j / p), b,
                $sformatf("%s[%0d]", tag, j));
      else
        add_row(en, spin, (j < sw) ? sel0 : sel1, 1'b1, 1'b0, 16'd0, b,
                $sformatf("%s[%0d]", tag, j));
    end
  endtask

  task automatic add_drop(input bit b, input string tag);
    add_row(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'd0, b, tag);
  endtask

  task automatic drive(input logic en, input logic spin, input logic [1:0] sel);
    ifa.TIMER_EN = en; ifa.SPIN_EN = spin; ifa.TIMER_SEL = sel;
    ifb.TIMER_EN = en; ifb.SPIN_EN = spin; ifb.TIMER_SEL = sel;
  endtask

  task automatic run_vectors();
    vec_t v;
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.en, v.spin, v.sel);
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.b) begin
        check({e.tag, " done"}, 32'(ifb.TIMER_DONE), 32'(e.done));
        check({e.tag, " busy"}, 32'(ifb.BUSY), 32'(e.busy));
        check({e.tag, " rem"}, 32'(ifb.REMAINING), 32'(e.rem));
      end else begin
        check({e.tag, " done"}, 32'(ifa.TIMER_DONE), 32'(e.done));
        check({e.tag, " busy"}, 32'(ifa.BUSY), 32'(e.busy));
        check({e.tag, " rem"}, 32'(ifa.REMAINING), 32'(e.rem));
      end
    end
    vecs.delete();
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'b00);
    #12;
    check("reset done", 32'(ifa.TIMER_DONE), 32'd0);
    check("reset busy", 32'(ifa.BUSY), 32'd0);
    check("reset rem", 32'(ifa.REMAINING), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Idle with select wiggling: nothing starts without a request.
    add_row(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 16'd0, 1'b0, "idle0");
    add_row(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 16'd0, 1'b0, "idle1");

    // 1: medium wash, 12 cycles, then drop.
    add_run(1'b1, 1'b0, 2'b01, 2'b01, 0, 3, 4, 14, 1'b0, "t1");
    add_drop(1'b0, "t1 drop");

    // 2: high wash aborted at E0+7, then immediate full 20-cycle rerun.
    add_run(1'b1, 1'b0, 2'b10, 2'b10, 0, 5, 4, 7, 1'b0, "t2a");
    add_drop(1'b0, "t2 abort");
    add_run(1'b1, 1'b0, 2'b10, 2'b10, 0, 5, 4, 21, 1'b0, "t2b");
    add_drop(1'b0, "t2 drop");

    // 3: spin, then held 5 more cycles with select changed: no restart.
    add_run(1'b0, 1'b1, 2'b11, 2'b01, 10, 2, 4, 14, 1'b0, "t3");
    add_drop(1'b0, "t3 drop");

    // 4: select switched mid-run is ignored.
    add_run(1'b1, 1'b0, 2'b01, 2'b10, 3, 3, 4, 13, 1'b0, "t4");
    add_drop(1'b0, "t4 drop");

    // Both request sources high act as one request.
    add_run(1'b1, 1'b1, 2'b00, 2'b00, 0, 1, 4, 6, 1'b0, "both");
    add_drop(1'b0, "both drop");

    // 6: PRESCALE=1 instance, T=1 back-to-back with one low edge between.
    add_run(1'b1, 1'b0, 2'b00, 2'b00, 0, 1, 1, 2, 1'b1, "t6a");
    add_drop(1'b1, "t6a drop");
    add_run(1'b1, 1'b0, 2'b00, 2'b00, 0, 1, 1, 3, 1'b1, "t6b");
    add_drop(1'b1, "t6b drop");
    add_run(1'b0, 1'b1, 2'b10, 2'b10, 0, 5, 1, 7, 1'b1, "t6c");
    add_drop(1'b1, "t6c drop");
    run_vectors();

    // 5: asynchronous reset mid-run, then release with the request held.
    add_run(1'b1, 1'b0, 2'b01, 2'b01, 0, 3, 4, 6, 1'b0, "t5pre");
    run_vectors();
    #1;
    rst_n = 1'b0;
    #1;
    check("t5 async done", 32'(ifa.TIMER_DONE), 32'd0);
    check("t5 async busy", 32'(ifa.BUSY), 32'd0);
    check("t5 async rem", 32'(ifa.REMAINING), 32'd0);
    @(posedge clk);
    #1;
    check("t5 held busy", 32'(ifa.BUSY), 32'd0);
    #2;
    rst_n = 1'b1;
    add_run(1'b1, 1'b0, 2'b01, 2'b01, 0, 3, 4, 14, 1'b0, "t5post");
    add_drop(1'b0, "t5 drop");
    run_vectors();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
